dcc_loop_ctrl: RTL and testbench
================================

Name: dcc_loop_ctrl

Overview:
- Digital duty-cycle-correction loop controller; sits directly downstream of the thermometer-code duty-cycle measurement stage (DCM).
- Drives that stage's request/finish/pos_neg handshake and samples its theta thermometer word.
- Averages positive-phase and negative-phase measurements and steps a saturating correction code for the delay-line DCC actuator.

Parameters:
- LEVEL, 20, thermometer width of theta; CNT_W = clog2(LEVEL+1).
- AVG_LOG2, 2, log2 of measurements averaged per phase; SUM_W = CNT_W+AVG_LOG2.
- CODE_W, 6, correction code width.
- DEADBAND, 1, allowed |sum_pos - sum_neg| with no code step, in SUM_W LSBs.
- SETTLE, 2, clk_in cycles waited after synchronized ready before sampling theta.
- TIMEOUT, 255, max clk_in cycles waiting for a ready edge.
- LOCK_CNT, 4, consecutive in-band updates required to assert locked.

Ports:
- clk_in, input, 1, controller clock.
- rst, input, 1, reset: one clock; reset is asynchronous and active-high.
- en, input, 1, loop enable; low forces IDLE after the current handshake closes.
- theta, input, LEVEL, thermometer word from the measurement stage.
- ready, input, 1, measurement-done from the measurement stage; asynchronous, 2-flop synchronized.
- request, output, 1, measurement request.
- finish, output, 1, measurement release.
- pos_neg, output, 1, 0 = measure high phase, 1 = measure low phase.
- dcc_code, output, CODE_W, correction code.
- code_valid, output, 1, one-cycle pulse on each update.
- locked, output, 1, loop in band.
- timeout_err, output, 1, sticky handshake timeout.
- meas_pos, output, SUM_W, last positive-phase sum.
- meas_neg, output, SUM_W, last negative-phase sum.

Behaviour:
- Reset values: request=0, finish=0, pos_neg=0, dcc_code=2^(CODE_W-1) (e.g. 32), code_valid=0, locked=0, timeout_err=0, meas_pos=0, meas_neg=0, internal counters 0, state IDLE.
- rdy_s is ready after 2 flops; all handshake decisions use rdy_s only.
- IDLE: when en=1 and timeout_err=0, go to REQ. Phase=0, sample index=0, accumulators cleared.
- REQ: request=1, pos_neg=phase, timer cleared; go to WAIT_RDY.
- WAIT_RDY: hold request. On rdy_s=1 go to SETTLE. If timer reaches TIMEOUT: request=0, timeout_err=1, go to IDLE.
- SETTLE: count SETTLE cycles, then go to SAMPLE.
- SAMPLE: cnt = popcount(theta), CNT_W bits, bubble-tolerant. Add cnt to acc[phase]. Drop request; go to FIN.
- FIN: finish=1, timer cleared, until rdy_s=0; then finish=0, go to NEXT. If TIMEOUT expires first: finish=0, timeout_err=1, go to IDLE.
- NEXT: increment sample index; when it wraps at 2^AVG_LOG2, toggle phase.
  - If the next phase is 0, go to UPDATE; otherwise go to REQ.
  - If en=0, go to IDLE; the in-progress average is discarded and no update occurs.
- pos_neg changes only in NEXT/IDLE, never while request or finish is high.
- UPDATE, one cycle:
  - Copy acc0 to meas_pos and acc1 to meas_neg; pulse code_valid.
  - If meas_pos > meas_neg+DEADBAND: dcc_code decrements, saturating at 0.
  - If meas_neg > meas_pos+DEADBAND: dcc_code increments, saturating at 2^CODE_W-1.
  - Otherwise hold dcc_code and increment inband_cnt, saturating.
  - Any step, including a saturated attempt, clears inband_cnt.
  - locked = (inband_cnt >= LOCK_CNT).
  - Comparisons use SUM_W+1 bits with no wrap. Go to REQ.
- timeout_err clears only on rst, or when en is low for at least 1 cycle.
- Async rst mid-handshake drops request/finish immediately and restores all reset values.

Test Plan:
- Model returns ready after 5 cycles; theta pos = 12 ones, neg = 8 ones; AVG_LOG2=2 -> meas_pos=48, meas_neg=32, dcc_code 32->31, code_valid for 1 cycle, locked=0.
- Balanced theta, 10 ones on both phases -> code stays 32, locked rises on the 4th update; one imbalanced round then clears locked.
- |diff|=1 (pos 10/10/10/11, neg 10 x4) -> within DEADBAND, no step; pos 11 x4 vs neg 10 x4 -> step down.
- Force dcc_code to 0 and keep pos > neg -> stays 0, inband_cnt stays 0; symmetric case at 63.
- ready never asserts -> request drops after 255 cycles, timeout_err=1, no further requests until en toggles low then high.
- Assert rst while finish=1 -> finish=0 and request=0 immediately, dcc_code=32; bubbled theta (1101111...) counted by popcount.

Source files
------------

// File: rtl/dcc_loop_ctrl.sv
// Duty-cycle-correction loop controller: runs the DCM request/finish handshake,
// averages per-phase theta popcounts and steps a saturating DCC correction code.
module dcc_loop_ctrl #(
  parameter int unsigned LEVEL    = 20,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned CODE_W   = 6,
  parameter int unsigned DEADBAND = 1,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned LOCK_CNT = 4,
  localparam int unsigned CNT_W   = $clog2(LEVEL + 1),
  localparam int unsigned SUM_W   = CNT_W + AVG_LOG2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [LEVEL-1:0]  theta,
  input  logic              ready,
  output logic              request,
  output logic              finish,
  output logic              pos_neg,
  output logic [CODE_W-1:0] dcc_code,
  output logic              code_valid,
  output logic              locked,
  output logic              timeout_err,
  output logic [SUM_W-1:0]  meas_pos,
  output logic [SUM_W-1:0]  meas_neg
);

  localparam int unsigned TMR_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IB_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SETTLE,
    S_SAMPLE,
    S_FIN,
    S_NEXT,
    S_UPDATE
  } state_e;

  state_e              state_q, state_d;
  logic                rdy_meta_q, rdy_s_q;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [AVG_LOG2-1:0] idx_q, idx_d;
  logic [SUM_W-1:0]    acc_pos_q, acc_pos_d;
  logic [SUM_W-1:0]    acc_neg_q, acc_neg_d;
  logic [SUM_W-1:0]    meas_pos_q, meas_pos_d;
  logic [SUM_W-1:0]    meas_neg_q, meas_neg_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [IB_W-1:0]     inband_q, inband_d;
  logic                request_q, request_d;
  logic                finish_q, finish_d;
  logic                pos_neg_q, pos_neg_d;
  logic                code_valid_q, code_valid_d;
  logic                locked_q, locked_d;
  logic                timeout_err_q, timeout_err_d;

  logic [CNT_W-1:0]    theta_cnt;
  logic [TMR_W:0]      timer_inc;
  logic                wait_expired;
  logic                settle_done;
  logic                idx_wrap;
  logic [SUM_W:0]      pos_ext, neg_ext;
  logic                step_dn, step_up;

  assign timer_inc    = {1'b0, timer_q} + (TMR_W+1)'(1);
  assign wait_expired = timer_inc >= (TMR_W+1)'(TIMEOUT);
  assign settle_done  = timer_inc >= (TMR_W+1)'(SETTLE);
  assign idx_wrap     = &idx_q;

  // One extra bit so deadband addition can never wrap.
  assign pos_ext = {1'b0, acc_pos_q};
  assign neg_ext = {1'b0, acc_neg_q};
  assign step_dn = pos_ext > (neg_ext + (SUM_W+1)'(DEADBAND));
  assign step_up = neg_ext > (pos_ext + (SUM_W+1)'(DEADBAND));

  // Plain popcount, so bubbles in the thermometer word still count.
  always_comb begin
    theta_cnt = '0;
    for (int unsigned i = 0; i < LEVEL; i++) begin
      theta_cnt = theta_cnt + CNT_W'(theta[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (en && !timeout_err_q) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT: begin
        if (rdy_s_q)           state_d = S_SETTLE;
        else if (wait_expired) state_d = S_IDLE;
      end
      S_SETTLE: if (settle_done) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_FIN;
      S_FIN: begin
        if (!rdy_s_q)          state_d = S_NEXT;
        else if (wait_expired) state_d = S_IDLE;
      end
      S_NEXT: begin
        if (!en)                        state_d = S_IDLE;
        else if (idx_wrap && pos_neg_q) state_d = S_UPDATE;
        else                            state_d = S_REQ;
      end
      S_UPDATE: state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    request_d     = request_q;
    finish_d      = finish_q;
    pos_neg_d     = pos_neg_q;
    code_d        = code_q;
    code_valid_d  = 1'b0;
    locked_d      = locked_q;
    timeout_err_d = timeout_err_q;
    meas_pos_d    = meas_pos_q;
    meas_neg_d    = meas_neg_q;
    acc_pos_d     = acc_pos_q;
    acc_neg_d     = acc_neg_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    inband_d      = inband_q;

    // A disabled loop acknowledges a previous handshake timeout.
    if (!en) timeout_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        request_d = 1'b0;
        finish_d  = 1'b0;
        pos_neg_d = 1'b0;
        idx_d     = '0;
        acc_pos_d = '0;
        acc_neg_d = '0;
      end
      S_REQ: begin
        request_d = 1'b1;
        timer_d   = '0;
      end
      S_WAIT: begin
        timer_d = timer_inc[TMR_W-1:0];
        if (rdy_s_q) begin
          timer_d = '0;
        end else if (wait_expired) begin
          request_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      S_SETTLE: timer_d = timer_inc[TMR_W-1:0];
      S_SAMPLE: begin
        if (pos_neg_q) acc_neg_d = acc_neg_q + SUM_W'(theta_cnt);
        else           acc_pos_d = acc_pos_q + SUM_W'(theta_cnt);
        request_d = 1'b0;
        finish_d  = 1'b1;
        timer_d   = '0;
      end
      S_FIN: begin
        if (!rdy_s_q) begin
          finish_d = 1'b0;
        end else begin
          timer_d = timer_inc[TMR_W-1:0];
          if (wait_expired) begin
            finish_d      = 1'b0;
            timeout_err_d = 1'b1;
          end
        end
      end
      S_NEXT: begin
        if (en) begin
          idx_d = idx_q + AVG_LOG2'(1);
          if (idx_wrap) pos_neg_d = ~pos_neg_q;
        end
      end
      S_UPDATE: begin
        meas_pos_d   = acc_pos_q;
        meas_neg_d   = acc_neg_q;
        code_valid_d = 1'b1;
        acc_pos_d    = '0;
        acc_neg_d    = '0;
        // Saturated step attempts still count as out of band.
        if (step_dn) begin
          if (code_q != '0) code_d = code_q - CODE_W'(1);
          inband_d = '0;
        end else if (step_up) begin
          if (code_q != '1) code_d = code_q + CODE_W'(1);
          inband_d = '0;
        end else if (inband_q != '1) begin
          inband_d = inband_q + IB_W'(1);
        end
        locked_d = inband_d >= IB_W'(LOCK_CNT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rdy_meta_q    <= 1'b0;
      rdy_s_q       <= 1'b0;
      timer_q       <= '0;
      idx_q         <= '0;
      acc_pos_q     <= '0;
      acc_neg_q     <= '0;
      meas_pos_q    <= '0;
      meas_neg_q    <= '0;
      code_q        <= CODE_MID;
      inband_q      <= '0;
      request_q     <= 1'b0;
      finish_q      <= 1'b0;
      pos_neg_q     <= 1'b0;
      code_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      rdy_meta_q    <= ready;
      rdy_s_q       <= rdy_meta_q;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      acc_pos_q     <= acc_pos_d;
      acc_neg_q     <= acc_neg_d;
      meas_pos_q    <= meas_pos_d;
      meas_neg_q    <= meas_neg_d;
      code_q        <= code_d;
      inband_q      <= inband_d;
      request_q     <= request_d;
      finish_q      <= finish_d;
      pos_neg_q     <= pos_neg_d;
      code_valid_q  <= code_valid_d;
      locked_q      <= locked_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign request     = request_q;
  assign finish      = finish_q;
  assign pos_neg     = pos_neg_q;
  assign dcc_code    = code_q;
  assign code_valid  = code_valid_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_err_q;
  assign meas_pos    = meas_pos_q;
  assign meas_neg    = meas_neg_q;

endmodule

// File: tb/tb_dcc_loop_ctrl.sv
// Bench for dcc_loop_ctrl: a reactive DCM model serves queued theta words and a
// monitor scores every code_valid update against an arithmetic loop model.
module tb_dcc_loop_ctrl;

  localparam int LEVEL    = 20;
  localparam int DEADBAND = 1;
  localparam int LOCK_CNT = 4;
  localparam int CODE_MAX = 63;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] theta;
  logic        ready;
  logic        request, finish, pos_neg, code_valid, locked, timeout_err;
  logic [5:0]  dcc_code;
  logic [6:0]  meas_pos, meas_neg;

  dcc_loop_ctrl dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .theta       (theta),
    .ready       (ready),
    .request     (request),
    .finish      (finish),
    .pos_neg     (pos_neg),
    .dcc_code    (dcc_code),
    .code_valid  (code_valid),
    .locked      (locked),
    .timeout_err (timeout_err),
    .meas_pos    (meas_pos),
    .meas_neg    (meas_neg)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [19:0] th; bit phase; } meas_t;
  typedef struct { int mp; int mn; int code; bit lk; } exp_t;

  meas_t mq[$];
  exp_t  eq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    m_code = 32;
  int    m_inband = 0;
  bit    no_ready = 1'b0;
  int    mst = 0;
  int    mdly = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // style 0: thermometer, 1: thermometer with a bubble, 2: random scatter
  function automatic logic [19:0] mk_theta(input int n, input int style);
    logic [19:0] t;
    int k;
    int b;
    t = '0;
    if (style == 2) begin
      k = 0;
      while (k < n) begin
        b = int'($urandom_range(LEVEL - 1, 0));
        if (!t[b]) begin
          t[b] = 1'b1;
          k++;
        end
      end
    end else begin
      for (int i = 0; i < n; i++) t[i] = 1'b1;
      if (style == 1 && n >= 2 && n < LEVEL) begin
        t[n-2] = 1'b0;
        t[n]   = 1'b1;
      end
    end
    return t;
  endfunction

  task automatic push_meas(input int n, input bit ph, input int style);
    meas_t m;
    m.th    = mk_theta(n, style);
    m.phase = ph;
    mq.push_back(m);
  endtask

  // Reference loop behaviour on one completed average.
  task automatic expect_round(input int sp, input int sn);
    exp_t e;
    if (sp > sn + DEADBAND) begin
      if (m_code > 0) m_code--;
      m_inband = 0;
    end else if (sn > sp + DEADBAND) begin
      if (m_code < CODE_MAX) m_code++;
      m_inband = 0;
    end else begin
      m_inband++;
    end
    e.mp = sp; e.mn = sn; e.code = m_code; e.lk = (m_inband >= LOCK_CNT);
    eq.push_back(e);
  endtask

  task automatic round_u(input int pn, input int nn, input int style);
    for (int i = 0; i < 4; i++) push_meas(pn, 1'b0, style);
    for (int i = 0; i < 4; i++) push_meas(nn, 1'b1, style);
    expect_round(4 * pn, 4 * nn);
  endtask

  task automatic round_rand();
    int p [4];
    int n [4];
    int sp;
    int sn;
    sp = 0; sn = 0;
    for (int i = 0; i < 4; i++) begin
      p[i] = int'($urandom_range(LEVEL, 0));
      n[i] = int'($urandom_range(LEVEL, 0));
      sp += p[i];
      sn += n[i];
    end
    for (int i = 0; i < 4; i++) push_meas(p[i], 1'b0, 2);
    for (int i = 0; i < 4; i++) push_meas(n[i], 1'b1, 2);
    expect_round(sp, sn);
  endtask

  task automatic run_batch(input int rounds);
    int lim;
    int c;
    lim = rounds * 300 + 500;
    c = 0;
    en = 1'b1;
    while (eq.size() > 0 && c < lim) begin
      @(negedge clk_in);
      c++;
    end
    chk("batch_drained", eq.size(), 0);
    eq.delete();
    en = 1'b0;
    repeat (120) @(negedge clk_in);
    mq.delete();
  endtask

  // DCM model: answers request after 5 cycles, releases ready 2 cycles after finish.
  initial begin
    meas_t m;
    ready = 1'b0;
    theta = '0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        mst = 0;
        ready = 1'b0;
      end else begin
        case (mst)
          0: if (request) begin
            if (no_ready) begin
              mst = 4;
            end else begin
              if (mq.size() > 0) begin
                m = mq.pop_front();
                chk("pos_neg_at_request", int'(pos_neg), int'(m.phase));
                theta = m.th;
              end else begin
                theta = mk_theta(10, 0);
              end
              mdly = 5;
              mst = 1;
            end
          end
          1: begin
            mdly--;
            if (mdly == 0) begin
              ready = 1'b1;
              mst = 2;
            end
          end
          2: if (finish) begin
            mdly = 2;
            mst = 3;
          end
          3: begin
            mdly--;
            if (mdly == 0) begin
              ready = 1'b0;
              mst = 0;
            end
          end
          default: if (!request) mst = 0;
        endcase
      end
    end
  end

  // Scoreboard monitor: every update must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (!rst && code_valid) begin
        if (eq.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          e = eq.pop_front();
          chk("meas_pos", int'(meas_pos), e.mp);
          chk("meas_neg", int'(meas_neg), e.mn);
          chk("dcc_code", int'(dcc_code), e.code);
          chk("locked", int'(locked), int'(e.lk));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int c;
    int hi;
    bit saw;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_request", int'(request), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_pos_neg", int'(pos_neg), 0);
    chk("rst_dcc_code", int'(dcc_code), 32);
    chk("rst_code_valid", int'(code_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_meas_pos", int'(meas_pos), 0);
    chk("rst_meas_neg", int'(meas_neg), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("idle_no_request", int'(request), 0);

    // Imbalance step, lock acquisition, lock loss, deadband hold, small step.
    round_u(12, 8, 0);
    for (int r = 0; r < 5; r++) round_u(10, 10, 1);
    round_u(12, 8, 2);
    push_meas(10, 1'b0, 0); push_meas(10, 1'b0, 2);
    push_meas(10, 1'b0, 1); push_meas(11, 1'b0, 2);
    for (int i = 0; i < 4; i++) push_meas(10, 1'b1, 2);
    expect_round(41, 40);
    round_u(11, 10, 0);
    run_batch(9);

    // Walk the code to both rails and push past each one.
    for (int r = 0; r < 32; r++) round_u(12, 8, 2);
    for (int r = 0; r < 66; r++) round_u(8, 12, 0);
    run_batch(98);

    // Bubbled theta round, then asynchronous reset while finish is high.
    round_u(12, 8, 1);
    en = 1'b1;
    c = 0;
    while (eq.size() > 0 && c < 600) begin
      @(negedge clk_in);
      c++;
    end
    chk("bubble_round_drained", eq.size(), 0);
    c = 0;
    while (!finish && c < 200) begin
      @(negedge clk_in);
      c++;
    end
    chk("finish_before_rst", int'(finish), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_request", int'(request), 0);
    chk("async_rst_finish", int'(finish), 0);
    chk("async_rst_dcc_code", int'(dcc_code), 32);
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_meas_pos", int'(meas_pos), 0);
    en = 1'b0;
    mq.delete();
    eq.delete();
    m_code = 32;
    m_inband = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
    round_u(8, 12, 0);
    run_batch(1);

    for (int r = 0; r < 20; r++) round_rand();
    run_batch(20);

    // Handshake timeout: ready never comes back.
    no_ready = 1'b1;
    en = 1'b1;
    c = 0;
    while (!request && c < 20) begin
      @(negedge clk_in);
      c++;
    end
    chk("timeout_req_rise", int'(request), 1);
    hi = 0;
    while (request && hi < 400) begin
      hi++;
      @(negedge clk_in);
    end
    chk("timeout_req_cycles", hi, 255);
    @(negedge clk_in);
    chk("timeout_err_set", int'(timeout_err), 1);
    saw = 1'b0;
    repeat (300) begin
      @(negedge clk_in);
      if (request) saw = 1'b1;
    end
    chk("no_request_while_err", int'(saw), 0);
    chk("timeout_err_sticky", int'(timeout_err), 1);
    en = 1'b0;
    @(negedge clk_in);
    chk("timeout_err_cleared", int'(timeout_err), 0);
    no_ready = 1'b0;
    en = 1'b1;
    c = 0;
    while (!request && c < 20) begin
      @(negedge clk_in);
      c++;
    end
    chk("request_resumes", int'(request), 1);
    en = 1'b0;
    repeat (150) @(negedge clk_in);
    chk("final_no_pending", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
